cska_sub_pipe: RTL and testbench

//  Pipelined carry(borrow)-skip subtractor: DIFF = A - B - BIN, the inverse

---
 rtl/cska_sub_pipe_if.sv | 26 ++
 rtl/cska_sub_pipe.sv | 98 +++++++++
 tb/tb_cska_sub_pipe.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cska_sub_pipe_if.sv
// Operand/result handshake bundle for the pipelined borrow-skip subtractor.
// master drives operands and out_ready; slave is the subtractor itself.
interface cska_sub_pipe_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/cska_sub_pipe.sv
// Pipelined carry(borrow)-skip subtractor: DIFF = A - B - BIN.
// One borrow-skip block per register stage, valid/ready flow control.
module cska_sub_pipe #(
    parameter int N          = 8,
    parameter int BLOCK_SIZE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    cska_sub_pipe_if.slave    io
);
    localparam int BLOCKS = N / BLOCK_SIZE;
    localparam int LAST   = BLOCKS - 1;

    logic [BLOCKS-1:0] vld_q, vld_d;
    logic [BLOCKS-1:0] brw_q, brw_d;
    logic [N-1:0]      a_q   [BLOCKS];
    logic [N-1:0]      a_d   [BLOCKS];
    logic [N-1:0]      b_q   [BLOCKS];
    logic [N-1:0]      b_d   [BLOCKS];
    logic [N-1:0]      dif_q [BLOCKS];
    logic [N-1:0]      dif_d [BLOCKS];
    logic              advance;

    // Whole pipe moves as one; a free or draining output slot lets it shift.
    assign advance = io.out_ready | ~vld_q[LAST];

    always_comb begin
        logic [N-1:0] sa, sb, sd;
        logic         sbr, br, pb, p, g;
        vld_d = '0;
        brw_d = '0;
        sa    = '0;
        sb    = '0;
        sd    = '0;
        sbr   = 1'b0;
        br    = 1'b0;
        pb    = 1'b0;
        p     = 1'b0;
        g     = 1'b0;
        for (int k = 0; k < BLOCKS; k++) begin
            if (k == 0) begin
                sa       = io.a;
                sb       = io.b;
                sbr      = io.bin;
                sd       = '0;
                vld_d[k] = io.in_valid;
            end else begin
                sa       = a_q[k-1];
                sb       = b_q[k-1];
                sbr      = brw_q[k-1];
                sd       = dif_q[k-1];
                vld_d[k] = vld_q[k-1];
            end
            br = sbr;
            pb = 1'b1;
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                p  = ~(sa[k*BLOCK_SIZE+j] ^ sb[k*BLOCK_SIZE+j]);
                g  = ~sa[k*BLOCK_SIZE+j] & sb[k*BLOCK_SIZE+j];
                sd[k*BLOCK_SIZE+j] = sa[k*BLOCK_SIZE+j]
                                   ^ sb[k*BLOCK_SIZE+j] ^ br;
                br = g | (p & br);
                pb = pb & p;
            end
            a_d[k]   = sa;
            b_d[k]   = sb;
            dif_d[k] = sd;
            // Skip mux: a fully propagating block passes its borrow-in.
            brw_d[k] = pb ? sbr : br;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            brw_q <= '0;
            for (int k = 0; k < BLOCKS; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                dif_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            brw_q <= brw_d;
            for (int k = 0; k < BLOCKS; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                dif_q[k] <= dif_d[k];
            end
        end
    end

    assign io.in_ready  = advance;
    assign io.out_valid = vld_q[LAST];
    assign io.diff      = dif_q[LAST];
    assign io.bout      = brw_q[LAST];
    assign io.ovf       = (a_q[LAST][N-1] != b_q[LAST][N-1])
                        & (dif_q[LAST][N-1] != a_q[LAST][N-1]);
endmodule

// File: tb/tb_cska_sub_pipe.sv
// Directed and randomised checks of the pipelined borrow-skip subtractor
// at N=8/BS=2 (four stages) and N=16/BS=4.
module tb_cska_sub_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cska_sub_pipe_if #(.N(8))  if8  ();
    cska_sub_pipe_if #(.N(16)) if16 ();

    cska_sub_pipe #(.N(8), .BLOCK_SIZE(2)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if8)
    );

    cska_sub_pipe #(.N(16), .BLOCK_SIZE(4)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if16)
    );

    // Reference: {ovf, bout, diff}
    function automatic logic [9:0] exp8(input logic [7:0] a, b, input logic bin);
        logic [8:0] r;
        r = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        return {(a[7] != b[7]) && (r[7] != a[7]), r[8], r[7:0]};
    endfunction

    function automatic logic [17:0] exp16(input logic [15:0] a, b, input logic bin);
        logic [16:0] r;
        r = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        return {(a[15] != b[15]) && (r[15] != a[15]), r[16], r[15:0]};
    endfunction

    // Drives one op into an idle 8-bit pipe; lat counts edges incl. accept.
    task automatic send8(input logic [7:0] a, b, input logic bin,
                         output logic [9:0] got, output int lat);
        if8.in_valid = 1'b1;
        if8.a = a;
        if8.b = b;
        if8.bin = bin;
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        lat = 1;
        while (!if8.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = {if8.ovf, if8.bout, if8.diff};
    endtask

    task automatic test_reset;
        if8.in_valid = 1'b1;
        if8.a = 8'hFF;
        if8.b = 8'h01;
        if8.bin = 1'b0;
        if8.out_ready = 1'b1;
        if16.in_valid = 1'b0;
        if16.a = '0;
        if16.b = '0;
        if16.bin = 1'b0;
        if16.out_ready = 1'b1;
        #2;
        checks++;
        if ({if8.out_valid, if8.ovf, if8.bout, if8.diff} !== 11'd0) begin
            errors++;
            $display("FAIL reset8_outputs got %b want 0",
                     {if8.out_valid, if8.ovf, if8.bout, if8.diff});
        end
        checks++;
        if ({if16.out_valid, if16.ovf, if16.bout, if16.diff} !== 19'd0) begin
            errors++;
            $display("FAIL reset16_outputs got %b want 0",
                     {if16.out_valid, if16.ovf, if16.bout, if16.diff});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (if8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset8_ignores_input got %b want 0", if8.out_valid);
        end
        if8.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (if8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset8_in_ready got %b want 1", if8.in_ready);
        end
        checks++;
        if (if8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset8_out_valid got %b want 0", if8.out_valid);
        end
    endtask

    task automatic test_basic;
        logic [9:0] got;
        int lat;
        send8(8'h5A, 8'h3C, 1'b0, got, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL basic_latency got %0d want 4", lat);
        end
        checks++;
        if (got !== {1'b0, 1'b0, 8'h1E}) begin
            errors++;
            $display("FAIL basic_5A_3C got %h want %h", got, {2'b00, 8'h1E});
        end
        @(posedge clk); #1;
        checks++;
        if (if8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_dup got %b want 0", if8.out_valid);
        end
    endtask

    task automatic test_skip;
        logic [9:0] got;
        int lat;
        send8(8'hAA, 8'hAA, 1'b1, got, lat);
        checks++;
        if (got !== {1'b0, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL skip_AA_AA_1 got %h want %h", got, {2'b01, 8'hFF});
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL skip_latency got %0d want 4", lat);
        end
        @(posedge clk); #1;
        send8(8'h00, 8'h01, 1'b0, got, lat);
        checks++;
        if (got !== {1'b0, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL borrow_00_01 got %h want %h", got, {2'b01, 8'hFF});
        end
        @(posedge clk); #1;
        send8(8'h00, 8'h00, 1'b1, got, lat);
        checks++;
        if (got !== {1'b0, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL skip_00_00_1 got %h want %h", got, {2'b01, 8'hFF});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        logic [9:0] got;
        int lat;
        send8(8'h80, 8'h01, 1'b0, got, lat);
        checks++;
        if (got !== {1'b1, 1'b0, 8'h7F}) begin
            errors++;
            $display("FAIL ovf_80_01 got %h want %h", got, {2'b10, 8'h7F});
        end
        @(posedge clk); #1;
        send8(8'h7F, 8'hFF, 1'b0, got, lat);
        checks++;
        if (got !== {1'b1, 1'b1, 8'h80}) begin
            errors++;
            $display("FAIL ovf_7F_FF got %h want %h", got, {2'b11, 8'h80});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [9:0] q[$];
        logic [9:0] hold;
        logic [9:0] want;
        int sent, got, c, extra;
        sent = 0;
        got = 0;
        c = 0;
        extra = 0;
        hold = '0;
        while (got < 8 && c < 100) begin
            if (sent < 8) begin
                if8.in_valid = 1'b1;
                if8.a = 8'h10 + 8'(sent * 8'h17);
                if8.b = 8'h03 + 8'(sent * 8'h21);
                if8.bin = sent[0];
            end else begin
                if8.in_valid = 1'b0;
            end
            if8.out_ready = !(c >= 5 && c <= 7);
            @(negedge clk);
            if (c >= 5 && c <= 7) begin
                checks++;
                if (if8.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready c=%0d got %b want 0", c, if8.in_ready);
                end
                if (c > 5) begin
                    checks++;
                    if ({if8.out_valid, if8.ovf, if8.bout, if8.diff} !== {1'b1, hold}) begin
                        errors++;
                        $display("FAIL stall_stable c=%0d got %h want %h", c,
                                 {if8.out_valid, if8.ovf, if8.bout, if8.diff}, {1'b1, hold});
                    end
                end
                hold = {if8.ovf, if8.bout, if8.diff};
            end
            if (if8.in_valid && if8.in_ready) begin
                q.push_back(exp8(if8.a, if8.b, if8.bin));
                sent++;
            end
            if (if8.out_valid && if8.out_ready) begin
                checks++;
                want = (q.size() > 0) ? q.pop_front() : 10'h3FF;
                if ({if8.ovf, if8.bout, if8.diff} !== want) begin
                    errors++;
                    $display("FAIL stream_result #%0d got %h want %h", got,
                             {if8.ovf, if8.bout, if8.diff}, want);
                end
                got++;
            end
            @(posedge clk); #1;
            c++;
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        checks++;
        if (got !== 8) begin
            errors++;
            $display("FAIL stream_count got %0d want 8", got);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if8.out_valid) extra++;
            @(posedge clk); #1;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL stream_duplicates got %0d want 0", extra);
        end
    endtask

    task automatic test_reset_midstream;
        logic [9:0] got;
        int lat, stale;
        stale = 0;
        if8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if8.in_valid = 1'b1;
            if8.a = 8'h40 + 8'(i);
            if8.b = 8'h11;
            if8.bin = 1'b0;
            @(posedge clk); #1;
        end
        if8.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_valid got %b want 1", if8.out_valid);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({if8.out_valid, if8.ovf, if8.bout, if8.diff} !== 11'd0) begin
            errors++;
            $display("FAIL midrst_async_clear got %h want 0",
                     {if8.out_valid, if8.ovf, if8.bout, if8.diff});
        end
        if8.in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            if (if8.out_valid) stale++;
            @(posedge clk); #1;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL midrst_stale got %0d want 0", stale);
        end
        send8(8'h33, 8'h44, 1'b1, got, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL midrst_latency got %0d want 4", lat);
        end
        checks++;
        if (got !== {1'b0, 1'b1, 8'hEE}) begin
            errors++;
            $display("FAIL midrst_result got %h want %h", got, {2'b01, 8'hEE});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random16;
        logic [17:0] q[$];
        logic [17:0] want;
        int sent, got, cyc;
        sent = 0;
        got = 0;
        cyc = 0;
        while (got < 10000 && cyc < 60000) begin
            if16.in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
            if16.a = 16'($urandom);
            if16.b = 16'($urandom);
            if16.bin = 1'($urandom);
            if16.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (if16.in_valid && if16.in_ready) begin
                q.push_back(exp16(if16.a, if16.b, if16.bin));
                sent++;
            end
            if (if16.out_valid && if16.out_ready) begin
                checks++;
                want = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                if ({if16.ovf, if16.bout, if16.diff} !== want) begin
                    errors++;
                    $display("FAIL rand16 #%0d got %h want %h", got,
                             {if16.ovf, if16.bout, if16.diff}, want);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if16.in_valid = 1'b0;
        if16.out_ready = 1'b1;
        checks++;
        if (got !== 10000) begin
            errors++;
            $display("FAIL rand16_count got %0d want 10000", got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip();
        test_overflow();
        test_back_to_back();
        test_reset_midstream();
        test_random16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
